adc_temp_multi_conv: RTL and testbench

//  Multi-channel thermistor ADC code -> signed temperature converter for the greenhouse sensor bus.

---
 rtl/adc_temp_pkg.sv | 32 +++
 rtl/adc_temp_lin.sv | 87 ++++++++
 rtl/adc_temp_multi_conv.sv | 138 +++++++++++++
 tb/tb_adc_temp_multi_conv.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_temp_pkg.sv
// Shared widths, calibration constants and the output clamp for the thermistor converter.
package adc_temp_pkg;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned ADC_W       = 12;
  localparam int unsigned AVG_LOG2    = 2;
  localparam int unsigned TEMP_W      = 12;
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned D_W         = ADC_W + 1;
  localparam int unsigned P_W         = D_W + 10;
  localparam int unsigned SLOPE_SHIFT = 8;

  localparam int ZERO_CODE  = 2670;
  localparam int SLOPE_NUM  = 154;
  localparam int FAULT_CODE = 2000;
  localparam int TEMP_MIN   = -400;
  localparam int TEMP_MAX   = 800;

  typedef logic signed [TEMP_W-1:0] temp_t;

  // Saturate a scaled product to the reportable temperature range.
  function automatic temp_t clamp_temp(input logic signed [P_W-1:0] v);
    logic signed [P_W-1:0] lo;
    logic signed [P_W-1:0] hi;
    lo = P_W'(TEMP_MIN);
    hi = P_W'(TEMP_MAX);
    if (v > hi) return TEMP_W'(TEMP_MAX);
    if (v < lo) return TEMP_W'(TEMP_MIN);
    return TEMP_W'(v);
  endfunction

endpackage

// File: rtl/adc_temp_lin.sv
// Two-stage linearisation: offset removal, then scale/shift/clamp with fault override.
module adc_temp_lin
  import adc_temp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [ADC_W-1:0] in_avg,
  input  logic             in_flt,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output temp_t            out_temp,
  output logic             out_fault
);

  localparam logic signed [D_W-1:0] ZERO_S  = D_W'(ZERO_CODE);
  localparam logic signed [P_W-1:0] SLOPE_S = P_W'(SLOPE_NUM);

  logic                  v1_q, v1_d;
  logic signed [D_W-1:0] d1_q, d1_d;
  logic                  f1_q, f1_d;
  logic [CH_W-1:0]       c1_q, c1_d;
  logic                  ov_q, ov_d;
  logic [CH_W-1:0]       oc_q, oc_d;
  temp_t                 ot_q, ot_d;
  logic                  of_q, of_d;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] scaled;

  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    f1_d   = f1_q;
    c1_d   = c1_q;
    ov_d   = ov_q;
    oc_d   = oc_q;
    ot_d   = ot_q;
    of_d   = of_q;
    prod   = P_W'(d1_q) * SLOPE_S;
    scaled = prod >>> SLOPE_SHIFT;
    // Whole pipeline moves together; a stalled output freezes both stages.
    if (adv) begin
      v1_d = in_valid;
      if (in_valid) begin
        d1_d = signed'({1'b0, in_avg}) - ZERO_S;
        f1_d = in_flt;
        c1_d = in_ch;
      end
      ov_d = v1_q;
      if (v1_q) begin
        oc_d = c1_q;
        ot_d = f1_q ? temp_t'(0) : clamp_temp(scaled);
        of_d = f1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      f1_q <= 1'b0;
      c1_q <= '0;
      ov_q <= 1'b0;
      oc_q <= '0;
      ot_q <= '0;
      of_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
      f1_q <= f1_d;
      c1_q <= c1_d;
      ov_q <= ov_d;
      oc_q <= oc_d;
      ot_q <= ot_d;
      of_q <= of_d;
    end
  end

  assign out_valid = ov_q;
  assign out_ch    = oc_q;
  assign out_temp  = ot_q;
  assign out_fault = of_q;

endmodule

// File: rtl/adc_temp_multi_conv.sv
// Per-channel window averaging of tagged ADC samples feeding the linearisation pipeline.
// Optional per-channel threshold alarms are built when TEMP_ALARM_EN is defined.
module adc_temp_multi_conv
  import adc_temp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [ADC_W-1:0]  s_code,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_ch,
  output temp_t             m_temp,
  output logic              m_fault,
  input  temp_t             thr_hi,
  input  temp_t             thr_lo,
  output logic [NUM_CH-1:0] alarm_hi,
  output logic [NUM_CH-1:0] alarm_lo
);

  localparam int unsigned    ACC_W    = ADC_W + AVG_LOG2;
  localparam int unsigned    CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] flt_q, flt_d;
  logic              adv;
  logic              ch_ok;
  logic [ACC_W-1:0]  sum;
  logic              samp_flt;
  logic              win_done;
  logic [ADC_W-1:0]  win_avg;
  logic              win_flt;

  assign adv     = !m_valid | m_ready;
  assign s_ready = adv;

  // Tags beyond the channel count are consumed but never accumulated.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = ({1'b0, s_ch} < (CH_W + 1)'(NUM_CH));
    end
  endgenerate

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    flt_d    = flt_q;
    win_done = 1'b0;
    win_avg  = '0;
    win_flt  = 1'b0;
    sum      = acc_q[s_ch] + ACC_W'(s_code);
    samp_flt = (s_code < ADC_W'(FAULT_CODE));
    if (s_valid && adv && ch_ok) begin
      if (cnt_q[s_ch] == CNT_LAST) begin
        win_done      = 1'b1;
        win_avg       = ADC_W'(sum >> AVG_LOG2);
        win_flt       = flt_q[s_ch] | samp_flt;
        acc_d[s_ch]   = '0;
        cnt_d[s_ch]   = '0;
        flt_d[s_ch]   = 1'b0;
      end else begin
        acc_d[s_ch]   = sum;
        cnt_d[s_ch]   = cnt_q[s_ch] + CNT_W'(1);
        flt_d[s_ch]   = flt_q[s_ch] | samp_flt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      flt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      flt_q <= flt_d;
    end
  end

  adc_temp_lin u_lin (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .in_valid  (win_done),
    .in_avg    (win_avg),
    .in_flt    (win_flt),
    .in_ch     (s_ch),
    .out_valid (m_valid),
    .out_ch    (m_ch),
    .out_temp  (m_temp),
    .out_fault (m_fault)
  );

`ifdef TEMP_ALARM_EN
  logic [NUM_CH-1:0] alarm_hi_q, alarm_hi_d;
  logic [NUM_CH-1:0] alarm_lo_q, alarm_lo_d;

  // Flags refresh only when their channel's result is actually transferred.
  always_comb begin
    alarm_hi_d = alarm_hi_q;
    alarm_lo_d = alarm_lo_q;
    if (m_valid && m_ready) begin
      alarm_hi_d[m_ch] = !m_fault && (m_temp > thr_hi);
      alarm_lo_d[m_ch] = !m_fault && (m_temp < thr_lo);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hi_q <= '0;
      alarm_lo_q <= '0;
    end else begin
      alarm_hi_q <= alarm_hi_d;
      alarm_lo_q <= alarm_lo_d;
    end
  end

  assign alarm_hi = alarm_hi_q;
  assign alarm_lo = alarm_lo_q;
`else
  logic unused_thr;
  assign unused_thr = ^{thr_hi, thr_lo};
  assign alarm_hi   = '0;
  assign alarm_lo   = '0;
`endif

endmodule

// File: tb/tb_adc_temp_multi_conv.sv
// Directed bench for adc_temp_multi_conv: averaging, linearisation, faults, ordering, stall, reset.
module tb_adc_temp_multi_conv;
  import adc_temp_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [CH_W-1:0]   s_ch;
  logic [ADC_W-1:0]  s_code;
  logic              m_valid;
  logic              m_ready;
  logic [CH_W-1:0]   m_ch;
  temp_t             m_temp;
  logic              m_fault;
  temp_t             thr_hi;
  temp_t             thr_lo;
  logic [NUM_CH-1:0] alarm_hi;
  logic [NUM_CH-1:0] alarm_lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef TEMP_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic [CH_W-1:0] q_ch [$];
  temp_t           q_t  [$];
  logic            q_f  [$];
  int              q_c  [$];

  adc_temp_multi_conv dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_ch     (s_ch),
    .s_code   (s_code),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_ch     (m_ch),
    .m_temp   (m_temp),
    .m_fault  (m_fault),
    .thr_hi   (thr_hi),
    .thr_lo   (thr_lo),
    .alarm_hi (alarm_hi),
    .alarm_lo (alarm_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer with the cycle it was presented.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      q_ch.push_back(m_ch);
      q_t.push_back(m_temp);
      q_f.push_back(m_fault);
      q_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] code, output int acc_cyc);
    bit done;
    done    = 1'b0;
    acc_cyc = -1;
    s_valid = 1'b1;
    s_ch    = ch;
    s_code  = code;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept ch=%0d code=%0d got no s_ready want accept within 100 cycles", ch, code);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic send4(input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] code);
    int c;
    for (int i = 0; i < 4; i++) send(ch, code, c);
  endtask

  task automatic get_out(output bit ok, output logic [CH_W-1:0] ch, output temp_t t,
                         output logic f, output int c);
    ok = 1'b0;
    ch = '0;
    t  = '0;
    f  = 1'b0;
    c  = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (q_ch.size() > 0) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      ch = q_ch.pop_front();
      t  = q_t.pop_front();
      f  = q_f.pop_front();
      c  = q_c.pop_front();
    end
    step();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_ch    = '0;
    s_code  = '0;
    m_ready = 1'b1;
    thr_hi  = temp_t'(500);
    thr_lo  = temp_t'(-300);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++;
    if (m_ch !== '0 || m_temp !== '0 || m_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_data got ch=%0d temp=%0d fault=%b want 0/0/0", m_ch, m_temp, m_fault);
    end
    checks++;
    if (alarm_hi !== '0 || alarm_lo !== '0) begin
      errors++;
      $display("FAIL reset_alarms got hi=%b lo=%b want 0/0", alarm_hi, alarm_lo);
    end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int acc_c;
    bit ok;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    for (int i = 0; i < 4; i++) send(CH_W'(0), ADC_W'(2670), acc_c);
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_out got none want one result"); end
    checks++;
    if (ch !== CH_W'(0) || t !== temp_t'(0) || f !== 1'b0) begin
      errors++;
      $display("FAIL basic_data got ch=%0d temp=%0d fault=%b want 0/0/0", ch, t, f);
    end
    checks++;
    if (oc - acc_c !== 2) begin
      errors++;
      $display("FAIL basic_latency got %0d want 2", oc - acc_c);
    end
  endtask

  task automatic test_linear();
    logic [CH_W-1:0] w_ch   [4] = '{CH_W'(1), CH_W'(2), CH_W'(3), CH_W'(3)};
    int              w_code [4][4] = '{'{3670, 3670, 3670, 3670},
                                       '{3670, 3670, 2670, 2670},
                                       '{4000, 4000, 4000, 4000},
                                       '{2000, 2000, 2000, 2000}};
    int              w_exp  [4] = '{601, 300, 800, -400};
    int acc_c;
    bit ok;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) send(w_ch[w], ADC_W'(w_code[w][k]), acc_c);
      get_out(ok, ch, t, f, oc);
      checks++;
      if (!ok || ch !== w_ch[w] || t !== temp_t'(w_exp[w]) || f !== 1'b0) begin
        errors++;
        $display("FAIL linear_w%0d got ok=%b ch=%0d temp=%0d fault=%b want ch=%0d temp=%0d fault=0",
                 w, ok, ch, t, f, w_ch[w], w_exp[w]);
      end
    end
    step();
    checks++;
    if (alarm_hi !== (ALARM_ON ? 4'b0010 : 4'b0000)) begin
      errors++;
      $display("FAIL linear_alarm_hi got %b want %b", alarm_hi, ALARM_ON ? 4'b0010 : 4'b0000);
    end
    checks++;
    if (alarm_lo !== (ALARM_ON ? 4'b1000 : 4'b0000)) begin
      errors++;
      $display("FAIL linear_alarm_lo got %b want %b", alarm_lo, ALARM_ON ? 4'b1000 : 4'b0000);
    end
  endtask

  task automatic test_fault();
    int acc_c;
    bit ok;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    send(CH_W'(0), ADC_W'(2670), acc_c);
    send(CH_W'(0), ADC_W'(1999), acc_c);
    send(CH_W'(0), ADC_W'(2670), acc_c);
    send(CH_W'(0), ADC_W'(2670), acc_c);
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(0) || t !== temp_t'(0) || f !== 1'b1) begin
      errors++;
      $display("FAIL fault_window got ok=%b ch=%0d temp=%0d fault=%b want ch=0 temp=0 fault=1", ok, ch, t, f);
    end
    send4(CH_W'(0), ADC_W'(2670));
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(0) || t !== temp_t'(0) || f !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got ok=%b ch=%0d temp=%0d fault=%b want ch=0 temp=0 fault=0", ok, ch, t, f);
    end
  endtask

  task automatic test_interleave();
    int acc_c;
    bit ok;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    for (int i = 0; i < 4; i++) begin
      send(CH_W'(0), ADC_W'(2670), acc_c);
      send(CH_W'(1), ADC_W'(3670), acc_c);
    end
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(0) || t !== temp_t'(0)) begin
      errors++;
      $display("FAIL interleave_first got ok=%b ch=%0d temp=%0d want ch=0 temp=0", ok, ch, t);
    end
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(1) || t !== temp_t'(601)) begin
      errors++;
      $display("FAIL interleave_second got ok=%b ch=%0d temp=%0d want ch=1 temp=601", ok, ch, t);
    end
    repeat (5) step();
    checks++;
    if (q_ch.size() != 0) begin
      errors++;
      $display("FAIL interleave_extra got %0d extra results want 0", q_ch.size());
    end
  endtask

  task automatic test_stall();
    int acc_c;
    bit ok;
    bit seen;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    for (int i = 0; i < 3; i++) send(CH_W'(2), ADC_W'(3170), acc_c);
    m_ready = 1'b0;
    send4(CH_W'(1), ADC_W'(3670));
    send(CH_W'(2), ADC_W'(3170), acc_c);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_pending got m_valid=0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_ch !== CH_W'(1) || m_temp !== temp_t'(601)) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b rdy=%b ch=%0d temp=%0d want v=1 rdy=0 ch=1 temp=601",
                 i, m_valid, s_ready, m_ch, m_temp);
      end
    end
    step();
    m_ready = 1'b1;
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(1) || t !== temp_t'(601)) begin
      errors++;
      $display("FAIL stall_drain1 got ok=%b ch=%0d temp=%0d want ch=1 temp=601", ok, ch, t);
    end
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(2) || t !== temp_t'(300)) begin
      errors++;
      $display("FAIL stall_drain2 got ok=%b ch=%0d temp=%0d want ch=2 temp=300", ok, ch, t);
    end
    repeat (5) step();
    checks++;
    if (q_ch.size() != 0) begin
      errors++;
      $display("FAIL stall_dup got %0d extra results want 0", q_ch.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc_c;
    bit ok;
    logic [CH_W-1:0] ch;
    temp_t t;
    logic f;
    int oc;
    send(CH_W'(0), ADC_W'(2000), acc_c);
    send(CH_W'(0), ADC_W'(2000), acc_c);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    send4(CH_W'(0), ADC_W'(3670));
    get_out(ok, ch, t, f, oc);
    checks++;
    if (!ok || ch !== CH_W'(0) || t !== temp_t'(601) || f !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_result got ok=%b ch=%0d temp=%0d fault=%b want ch=0 temp=601 fault=0",
               ok, ch, t, f);
    end
    step();
    checks++;
    if (alarm_hi !== (ALARM_ON ? 4'b0001 : 4'b0000) || alarm_lo !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_alarm got hi=%b lo=%b want hi=%b lo=0000",
               alarm_hi, alarm_lo, ALARM_ON ? 4'b0001 : 4'b0000);
    end
    repeat (5) step();
    checks++;
    if (q_ch.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_extra got %0d extra results want 0", q_ch.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_linear();
    test_fault();
    test_interleave();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
